// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: 8-LED pattern sequencer, stepping once per TICK_DIV clocks, mode advanced by button.
// Optional build macro LED_AUTO_CYCLE_EN: auto-advance mode after REPEAT full passes of a pattern.
//
// state     | meaning
// FILL_UP   | bar grows from bit 0 towards bit 7
// FILL_DOWN | bar grows from bit 7 towards bit 0
// CHASE     | single lit LED walks from bit 0 to bit 7
// BLINK     | all LEDs on for odd steps, off for even steps
module led_mode_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int REPEAT   = 2
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       btn,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        FILL_UP   = 2'd0,
        FILL_DOWN = 2'd1,
        CHASE     = 2'd2,
        BLINK     = 2'd3
    } mode_t;

    if (TICK_DIV < 2 || TICK_DIV > (1 << 26)) begin : g_bad_tick_div
        $error("led_mode_ctrl: TICK_DIV out of range 2..2^26");
    end
    if (REPEAT < 1 || REPEAT > 15) begin : g_bad_repeat
        $error("led_mode_ctrl: REPEAT out of range 1..15");
    end

    mode_t         mode_q;
    logic [PW-1:0] presc;
    logic [2:0]    step;
    logic [3:0]    pass;
    logic          sync1;
    logic          sync2;
    logic          prev;
    logic          btn_rise;

    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        unique case (m)
            FILL_UP:   r = FILL_DOWN;
            FILL_DOWN: r = CHASE;
            CHASE:     r = BLINK;
            BLINK:     r = FILL_UP;
            default:   r = FILL_UP;
        endcase
        return r;
    endfunction

    // Reset to all-ones so a button held across reset release looks like "no edge".
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign btn_rise = sync2 & ~prev;
    assign tick     = (presc == PRESC_TC);

    // A button edge wins over a coincident tick; the tick is simply dropped.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            presc  <= '0;
            step   <= '0;
            pass   <= '0;
            mode_q <= FILL_UP;
        end else if (btn_rise) begin
            presc  <= '0;
            step   <= '0;
            pass   <= '0;
            mode_q <= next_mode(mode_q);
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                step <= step + 3'd1;
                if (step == 3'd7) begin
`ifdef LED_AUTO_CYCLE_EN
                    if (pass == 4'(REPEAT - 1)) begin
                        pass   <= '0;
                        mode_q <= next_mode(mode_q);
                    end else begin
                        pass <= pass + 4'd1;
                    end
`else
                    if (pass != 4'd15) begin
                        pass <= pass + 4'd1;
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        led = 8'h00;
        unique case (mode_q)
            FILL_UP:   led = 8'hFF >> (3'd7 - step);
            FILL_DOWN: led = 8'hFF << (3'd7 - step);
            CHASE:     led = 8'h01 << step;
            BLINK:     led = {8{step[0]}};
            default:   led = 8'h00;
        endcase
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: cycle-level behavioural model feeds an event scoreboard;
// a monitor pops and compares whenever the DUT ticks or changes mode.
`timescale 1ns/1ps
module tb_led_mode_ctrl;

    localparam int TD = 4;
    localparam int RP = 2;

    logic       clk = 1'b0;
    logic       rs  = 1'b0;
    logic       btn = 1'b0;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;

    led_mode_ctrl #(.TICK_DIV(TD), .REPEAT(RP)) dut (
        .clk  (clk),
        .rs   (rs),
        .btn  (btn),
        .led  (led),
        .mode (mode),
        .tick (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         tk;
        int         md;
        logic [7:0] ld;
    } ev_t;

    ev_t sbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model state: cycles since last restart, ticks since last restart/auto-advance.
    int m_cyc = 0;
    int m_elapsed = 0;
    int m_ticks = 0;
    int m_mode = 0;
    int m_mode_prev = 0;
    bit b1 = 1, b2 = 1, b3 = 1;

    function automatic logic [7:0] ref_led(input int md, input int s);
        logic [7:0] f;
        logic [7:0] r;
        f = 8'((1 << (s + 1)) - 1);
        r = 8'h00;
        case (md)
            0: r = f;
            1: for (int i = 0; i < 8; i++) r[7 - i] = f[i];
            2: r = 8'(1 << s);
            default: r = (s % 2 == 1) ? 8'hFF : 8'h00;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit adv;
        bit tick_prev;
        bit exp_tick;
        ev_t e;
        m_cyc++;
        if (!rs) begin
            m_elapsed = 0;
            m_ticks   = 0;
            m_mode    = 0;
            b1 = 1; b2 = 1; b3 = 1;
        end else begin
            // A high sample following a low sample advances the mode two edges later.
            adv       = b2 && !b3;
            b3 = b2; b2 = b1; b1 = btn;
            tick_prev = (m_elapsed % TD) == TD - 1;
            if (adv) begin
                m_mode    = (m_mode + 1) % 4;
                m_elapsed = 0;
                m_ticks   = 0;
            end else begin
                if (tick_prev) begin
                    m_ticks++;
`ifdef LED_AUTO_CYCLE_EN
                    if (m_ticks == 8 * RP) begin
                        m_mode  = (m_mode + 1) % 4;
                        m_ticks = 0;
                    end
`endif
                end
                m_elapsed++;
            end
        end
        exp_tick = (m_elapsed % TD) == TD - 1;
        if (exp_tick || m_mode != m_mode_prev) begin
            e.cyc = m_cyc;
            e.tk  = exp_tick;
            e.md  = m_mode;
            e.ld  = ref_led(m_mode, m_ticks % 8);
            sbq.push_back(e);
        end
        m_mode_prev = m_mode;
    end

    int         mon_cyc = 0;
    logic [1:0] mon_prev_mode = 2'd0;

    always @(posedge clk) begin
        ev_t e;
        #3;
        mon_cyc++;
        if (tick || mode != mon_prev_mode) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: cyc=%0d tick=%0b mode=%0d led=%02h, expected no event",
                         mon_cyc, tick, mode, led);
            end else begin
                e = sbq.pop_front();
                if (e.cyc != mon_cyc || e.tk != tick || e.md != int'(mode) || e.ld != led) begin
                    n_fail++;
                    $display("FAIL sb_event: got cyc=%0d tick=%0b mode=%0d led=%02h, expected cyc=%0d tick=%0b mode=%0d led=%02h",
                             mon_cyc, tick, mode, led, e.cyc, e.tk, e.md, e.ld);
                end
            end
            if (rs && mode != mon_prev_mode)
                check("mode_order", int'(mode), (int'(mon_prev_mode) + 1) % 4);
        end
        mon_prev_mode = mode;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int len);
        @(negedge clk);
        btn = 1'b1;
        repeat (len) @(negedge clk);
        btn = 1'b0;
    endtask

    initial begin
        bit found;
        // reset state
        rs  = 1'b0;
        btn = 1'b0;
        @(negedge clk);
        #1;
        check("rst_led", led, 8'h01);
        check("rst_mode", mode, 0);
        check("rst_tick", tick, 0);
        idle(3);
        rs = 1'b1;
        idle(32);

        // single-cycle button pulse
        @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        check("pulse_k1_mode", mode, 0);
        @(negedge clk);
        check("pulse_k2_mode", mode, 1);
        check("pulse_k2_led", led, 8'h80);
        idle(4);
        check("pulse_tick_led", led, 8'hC0);

        // button edge detected in the tick cycle
        idle(3);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_elapsed % TD == 1) found = 1;
        end
        check("align_found", int'(found), 1);
        btn = 1'b1;
        idle(2);
        check("align_tick", tick, 1);
        idle(1);
        check("align_mode", mode, 2);
        check("align_led", led, 8'h01);
        btn = 1'b0;

        // random pulses and holds
        for (int i = 0; i < 25; i++) begin
            idle($urandom_range(1, 30));
            pulse(($urandom_range(0, 7) == 0) ? 100 : $urandom_range(1, 6));
        end

        // hold for 100 cycles gives one advance
        idle(5);
        pulse(100);
        idle(5);

        // hold through reset release
        @(negedge clk);
        btn = 1'b1;
        idle(2);
        rs = 1'b0;
        idle(3);
        rs = 1'b1;
        idle(20);
        check("hold_rst_mode", mode, 0);
        btn = 1'b0;
        idle(3);

        // reset in CHASE at step 5
        for (int i = 0; i < 6 && m_mode != 2; i++) begin
            pulse(1);
            idle(4);
        end
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (m_mode == 2 && m_ticks % 8 == 5) found = 1;
        end
        check("chase_s5_found", int'(found), 1);
        check("chase_s5_led", led, 8'h20);
        rs = 1'b0;
        #1;
        check("chase_rst_led", led, 8'h01);
        check("chase_rst_mode", mode, 0);
        idle(2);
        rs = 1'b1;

        idle(1000);
`ifndef LED_AUTO_CYCLE_EN
        check("no_auto_mode", mode, 0);
`endif
        idle(4);
        check("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
